// File: rtl/four_bit_seq_divider.sv
// Sequential restoring divider: one quotient bit per clock,
// trial subtraction at WIDTH+1 bits with borrow-driven restore.
module four_bit_seq_divider #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] p;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] dvsr;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   p_sh;
  logic [WIDTH:0]   t;
  logic             borrow;
  logic             last;
  logic [WIDTH-1:0] p_nx;
  logic [WIDTH-1:0] q_nx;
  logic             dvsr_zero;

  // P' never exceeds 2*divisor-1, so the top bit of t is a clean borrow
  always_comb begin
    p_sh      = {p, q[WIDTH-1]};
    t         = p_sh - {1'b0, dvsr};
    borrow    = t[WIDTH];
    p_nx      = borrow ? p_sh[WIDTH-1:0] : t[WIDTH-1:0];
    q_nx      = {q[WIDTH-2:0], ~borrow};
    last      = (cnt == CW'(1));
    dvsr_zero = (divisor == '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    busy     = 1'b0;
    done     = 1'b0;
    unique case (state)
      IDLE: begin
        if (start)
          state_nx = dvsr_zero ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last) state_nx = DONE;
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p           <= '0;
      q           <= '0;
      dvsr        <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            if (dvsr_zero) begin
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              q    <= dividend;
              dvsr <= divisor;
              p    <= '0;
              cnt  <= CW'(WIDTH);
            end
          end
        end
        CALC: begin
          p   <= p_nx;
          q   <= q_nx;
          cnt <= cnt - 1'b1;
          if (last) begin
            quotient    <= q_nx;
            remainder   <= p_nx;
            div_by_zero <= 1'b0;
          end
        end
        DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_four_bit_seq_divider.sv
// Bench for four_bit_seq_divider: arithmetic reference model
// compared every cycle, plus directed literal expectations.
module tb_four_bit_seq_divider;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         busy;
  logic         done;
  logic         div_by_zero;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;

  four_bit_seq_divider #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .dividend(dividend),
    .divisor(divisor),
    .busy(busy),
    .done(done),
    .div_by_zero(div_by_zero),
    .quotient(quotient),
    .remainder(remainder)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Reference model: cycles left in the operation plus result registers
  int m_left = 0;
  bit m_done = 0;
  bit m_dbz = 0;
  int m_q = 0;
  int m_r = 0;
  int m_pq = 0;
  int m_pr = 0;
  int m_a = 0;
  int m_b = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_left = 0;
      m_done = 0;
      m_dbz  = 0;
      m_q    = 0;
      m_r    = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_left > 0) begin
      m_left--;
      if (m_left == 0) begin
        m_q    = m_pq;
        m_r    = m_pr;
        m_dbz  = 0;
        m_done = 1;
      end
    end else if (start) begin
      m_a = dividend;
      m_b = divisor;
      if (divisor == 0) begin
        m_q    = (1 << W) - 1;
        m_r    = dividend;
        m_dbz  = 1;
        m_done = 1;
      end else begin
        m_pq   = dividend / divisor;
        m_pr   = dividend % divisor;
        m_left = W;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", busy, int'(m_left > 0));
      chk("done", done, int'(m_done));
      chk("quotient", quotient, m_q);
      chk("remainder", remainder, m_r);
      chk("div_by_zero", div_by_zero, int'(m_dbz));
      if (done && !div_by_zero)
        chk("invariant", quotient * m_b + remainder, m_a);
    end
  end

  task automatic run_div(input int a, input int b,
                         output int lat, output int nbusy);
    bit seen;
    @(negedge clk);
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    seen  = 0;
    lat   = 0;
    nbusy = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (i == 1) start = 1'b0;
      if (busy) nbusy++;
      if (done) begin
        seen = 1;
        lat  = i;
        break;
      end
    end
    if (!seen) begin
      n_total++;
      $display("FAIL timeout: no done for %0d/%0d", a, b);
    end
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    if (!seen) begin
      n_total++;
      $display("FAIL timeout: %s", name);
    end
  endtask

  int lat, nb;
  int bt[4][4] = '{
    '{15, 15, 1, 0},
    '{3, 7, 0, 3},
    '{0, 1, 0, 0},
    '{15, 1, 15, 0}
  };

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_dbz", div_by_zero, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    run_div(13, 3, lat, nb);
    chk("13/3_lat", lat, W + 1);
    chk("13/3_busy_cycles", nb, W);
    chk("13/3_q", quotient, 4);
    chk("13/3_r", remainder, 1);
    chk("13/3_dbz", div_by_zero, 0);

    for (int k = 0; k < 4; k++) begin
      run_div(bt[k][0], bt[k][1], lat, nb);
      chk("bound_q", quotient, bt[k][2]);
      chk("bound_r", remainder, bt[k][3]);
    end

    run_div(9, 0, lat, nb);
    chk("9/0_lat", lat, 1);
    chk("9/0_q", quotient, 15);
    chk("9/0_r", remainder, 9);
    chk("9/0_dbz", div_by_zero, 1);
    repeat (3) @(negedge clk);
    chk("9/0_hold_q", quotient, 15);
    chk("9/0_hold_r", remainder, 9);
    chk("9/0_hold_dbz", div_by_zero, 1);

    // second start raised during CALC and held until accepted
    @(negedge clk);
    dividend = 4'd12;
    divisor  = 4'd5;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    dividend = 4'd6;
    divisor  = 4'd2;
    start    = 1'b1;
    wait_done("12/5");
    chk("12/5_q", quotient, 2);
    chk("12/5_r", remainder, 2);
    @(negedge clk);
    chk("held_idle_busy", busy, 0);
    @(negedge clk);
    chk("held_accept_busy", busy, 1);
    start = 1'b0;
    wait_done("6/2");
    chk("6/2_q", quotient, 3);
    chk("6/2_r", remainder, 0);

    // asynchronous reset between edges mid-division
    @(negedge clk);
    dividend = 4'd14;
    divisor  = 4'd3;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", done, 0);
    chk("midrst_q", quotient, 0);
    chk("midrst_r", remainder, 0);
    chk("midrst_dbz", div_by_zero, 0);
    @(negedge clk);
    rst = 1'b0;
    run_div(14, 3, lat, nb);
    chk("14/3_q", quotient, 4);
    chk("14/3_r", remainder, 2);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_div(a, b, lat, nb);
        if (b == 0) begin
          chk("sweep_dbz", div_by_zero, 1);
        end else begin
          chk("sweep_q", quotient, a / b);
          chk("sweep_r", remainder, a % b);
        end
      end
    end

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/four_bit_seq_divider.md
Name: four_bit_seq_divider

Overview:
- Sequential restoring divider built on the 4-bit subtract-with-borrow datapath.
- Each iteration shifts one dividend bit into a partial remainder and performs a trial subtraction of the divisor. The borrow out decides the quotient bit and whether the difference is kept or the old value restored.
- Sits directly downstream of the subtractor stage. It consumes Diff/Borrow-style results once per clock and produces quotient/remainder for the next stage.

Parameters:
- WIDTH, 4, operand width in bits; iteration count per division.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request to begin a division; sampled only in IDLE.
- dividend  input  WIDTH  unsigned dividend; captured on accepted start.
- divisor  input  WIDTH  unsigned divisor; captured on accepted start.
- busy  output  1  high while iterating (CALC state).
- done  output  1  one-cycle pulse when results become valid.
- div_by_zero  output  1  high with results when the captured divisor was 0.
- quotient  output  WIDTH  unsigned quotient.
- remainder  output  WIDTH  unsigned remainder.

Behaviour:
- Interface: one clock; reset is asynchronous and active-high. Ports are named clk and rst.
- Reset, asserted at any time including mid-division:
  - State = IDLE.
  - busy = 0, done = 0, div_by_zero = 0, quotient = 0, remainder = 0.
  - Internal partial remainder, shift register and iteration counter all cleared.
  - No pending operation survives reset.
- States: IDLE, CALC, DONE.
- IDLE, start=1, divisor≠0, at edge E:
  - Capture dividend into the shift register and divisor into the divisor register.
  - Clear partial remainder (WIDTH+1 bits) and load counter = WIDTH.
  - Go to CALC; busy = 1 after E.
- IDLE, start=1, divisor=0, at edge E:
  - Go to DONE.
  - quotient = all ones (4'hF for WIDTH=4), remainder = dividend, div_by_zero = 1, done = 1 after E.
- CALC, each edge:
  - P' = {P[WIDTH-1:0], Q[WIDTH-1]}; Q shifts left.
  - T = P' − {1'b0, divisor}, computed at WIDTH+1 bits; borrow = T[WIDTH].
  - borrow=0: P = T, Q[0] = 1.
  - borrow=1: P = P' (restore), Q[0] = 0.
  - Counter decrements.
  - On the edge that completes the WIDTH-th iteration: go to DONE, load quotient = Q and remainder = P[WIDTH-1:0], set busy = 0, done = 1, div_by_zero = 0.
- Latency: start accepted at edge E gives done high after edge E+WIDTH (E+1 for divide-by-zero).
- DONE: exactly one cycle. The next edge returns to IDLE with done = 0.
- Result holding: quotient, remainder and div_by_zero hold their values until the next accepted start or reset.
- start outside IDLE (CALC or DONE) is ignored. It is not queued, and a held start is accepted in the following IDLE cycle.
- Operand changes on dividend/divisor while busy have no effect on the current operation.
- Arithmetic:
  - Unsigned only. The trial subtraction is WIDTH+1 bits wide, so P' up to 2·divisor−1 never overflows.
  - Final P < divisor is guaranteed; remainder fits in WIDTH bits.
  - Invariant checked in simulation: dividend = quotient·divisor + remainder whenever done=1 and div_by_zero=0.
- Back-to-back operations: minimum spacing is WIDTH+2 cycles between accepted starts.

Test Plan:
- Normal division: rst pulse, then start with dividend=13 (4'b1101), divisor=3 → busy high for 4 cycles; done pulses at edge E+4 with quotient=4, remainder=1, div_by_zero=0.
- Boundary values:
  - dividend=15, divisor=15 → quotient=1, remainder=0.
  - dividend=3, divisor=7 → quotient=0, remainder=3.
  - dividend=0, divisor=1 → quotient=0, remainder=0.
  - dividend=15, divisor=1 → quotient=15, remainder=0.
- Divide by zero: dividend=9, divisor=0 → done after E+1, quotient=15, remainder=9, div_by_zero=1; outputs hold until the next start.
- Start while busy: start 12/5, then drive start=1 with 6/2 during CALC → first result quotient=2, remainder=2 is unaffected; second division begins only after returning to IDLE and yields quotient=3, remainder=0.
- Reset mid-operation: start 14/3, assert rst two cycles later (between clock edges) → all outputs 0 immediately, state IDLE; a subsequent 14/3 yields quotient=4, remainder=2.
- Exhaustive sweep: all 256 dividend/divisor pairs → each nonzero-divisor case matches the / and % reference model; each zero-divisor case flags div_by_zero.
